// File: rtl/quad_decoder.sv
// Quadrature decoder: 2-flop sync, stability filter, step decode, registered up/down pulses and count.
// Optional sticky illegal-jump flag on error_o when QUAD_DECODER_ERR_EN is defined.
module quad_decoder #(
  parameter int width_p  = 16,
  parameter int filter_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               a_i,
  input  logic               b_i,
  input  logic               clear_i,
  output logic               up_o,
  output logic               down_o,
  output logic [width_p-1:0] count_o,
  output logic               dir_o,
  output logic               error_o
);

  localparam logic [7:0]         FILT = 8'(filter_p);
  localparam logic [width_p-1:0] ONE  = 1;

  logic [1:0]         sync1_q, sync2_q, prev_q;
  logic [1:0]         acc_q, acc_d;
  logic [7:0]         stab_q, stab_d;
  logic               first_q, first_d;
  logic               fwd_q, fwd_d, rev_q, rev_d;
  logic               up_q, down_q, dir_q, dir_d;
  logic [width_p-1:0] count_q, count_d;
  logic               accept;
  logic [1:0]         old_idx, new_idx, diff;

  // Gray position index: 00->0, 01->1, 11->2, 10->3; forward is +1 mod 4.
  assign old_idx = {acc_q[1], acc_q[1] ^ acc_q[0]};
  assign new_idx = {sync2_q[1], sync2_q[1] ^ sync2_q[0]};
  assign diff    = new_idx - old_idx;

  always_comb begin
    stab_d = stab_q;
    if (sync2_q == acc_q && !first_q)
      stab_d = 8'd0;
    else if (sync2_q != prev_q)
      stab_d = 8'd1;
    else if (stab_q != 8'hFF)
      stab_d = stab_q + 8'd1;

    accept  = (stab_d == FILT);
    acc_d   = accept ? sync2_q : acc_q;
    first_d = first_q && !accept;
    fwd_d   = accept && !first_q && (diff == 2'd1);
    rev_d   = accept && !first_q && (diff == 2'd3);
    if (accept)
      stab_d = 8'd0;

    count_d = count_q;
    if (fwd_q)
      count_d = count_q + ONE;
    else if (rev_q)
      count_d = count_q - ONE;
    if (clear_i)
      count_d = '0;

    dir_d = dir_q;
    if (fwd_q)
      dir_d = 1'b1;
    else if (rev_q)
      dir_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync1_q <= 2'b00;
      sync2_q <= 2'b00;
      prev_q  <= 2'b00;
      acc_q   <= 2'b00;
      stab_q  <= 8'd0;
      first_q <= 1'b1;
      fwd_q   <= 1'b0;
      rev_q   <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      dir_q   <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= {a_i, b_i};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      acc_q   <= acc_d;
      stab_q  <= stab_d;
      first_q <= first_d;
      fwd_q   <= fwd_d;
      rev_q   <= rev_d;
      up_q    <= fwd_q;
      down_q  <= rev_q;
      dir_q   <= dir_d;
      count_q <= count_d;
    end
  end

`ifdef QUAD_DECODER_ERR_EN
  logic ill_q, err_q;

  // An illegal jump in the same cycle as clear_i wins, so the flag is never lost.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ill_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ill_q <= accept && !first_q && (diff == 2'd2);
      if (ill_q)
        err_q <= 1'b1;
      else if (clear_i)
        err_q <= 1'b0;
    end
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

  assign up_o    = up_q;
  assign down_o  = down_q;
  assign count_o = count_q;
  assign dir_o   = dir_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed bench for quad_decoder (width_p=4, filter_p=4); expected error_o follows QUAD_DECODER_ERR_EN.
module tb_quad_decoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a = 1'b0;
  logic       b = 1'b0;
  logic       clear = 1'b0;
  logic       up, down, dir, error;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;
  int up_cnt = 0;
  int down_cnt = 0;
  int both_cnt = 0;

  quad_decoder #(.width_p(4), .filter_p(4)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .a_i     (a),
    .b_i     (b),
    .clear_i (clear),
    .up_o    (up),
    .down_o  (down),
    .count_o (count),
    .dir_o   (dir),
    .error_o (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (up) up_cnt++;
    if (down) down_cnt++;
    if (up && down) both_cnt++;
  end

  task automatic set_ab(input logic [1:0] v);
    @(negedge clk);
    a = v[1];
    b = v[0];
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [1:0] v);
    set_ab(v);
    hold(10);
  endtask

  task automatic test_reset;
    hold(3);
    checks++;
    if ({up, down, dir, error} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got %b want 0000", {up, down, dir, error});
    end
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL reset_count got %0d want 0", count);
    end
    @(negedge clk);
    reset = 1'b0;
    hold(12);
    checks++;
    if (up_cnt !== 0 || down_cnt !== 0 || count !== 4'd0) begin
      errors++;
      $display("FAIL first_value got up=%0d down=%0d count=%0d want 0 0 0", up_cnt, down_cnt, count);
    end
  endtask

  task automatic test_forward;
    int u0, d0;
    u0 = up_cnt;
    d0 = down_cnt;
    set_ab(2'b01);
    hold(6);
    checks++;
    if (up !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got up=%b want 0", up);
    end
    hold(1);
    checks++;
    if (up !== 1'b1) begin
      errors++;
      $display("FAIL latency_edge7 got up=%b want 1", up);
    end
    hold(1);
    checks++;
    if (up !== 1'b0) begin
      errors++;
      $display("FAIL pulse_width got up=%b want 0", up);
    end
    hold(8);
    step(2'b11); step(2'b10); step(2'b00);
    step(2'b01); step(2'b11); step(2'b10); step(2'b00);
    checks++;
    if (up_cnt - u0 !== 8 || down_cnt - d0 !== 0) begin
      errors++;
      $display("FAIL fwd_pulses got up=%0d down=%0d want 8 0", up_cnt - u0, down_cnt - d0);
    end
    checks++;
    if (count !== 4'd8 || dir !== 1'b1) begin
      errors++;
      $display("FAIL fwd_count got count=%0d dir=%b want 8 1", count, dir);
    end
  endtask

  task automatic test_glitch;
    int u0, d0;
    u0 = up_cnt;
    d0 = down_cnt;
    set_ab(2'b10);
    hold(3);
    set_ab(2'b00);
    hold(20);
    checks++;
    if (up_cnt !== u0 || down_cnt !== d0 || count !== 4'd8) begin
      errors++;
      $display("FAIL glitch got up=%0d down=%0d count=%0d want 0 0 8", up_cnt - u0, down_cnt - d0, count);
    end
  endtask

  task automatic test_wrap;
    int u0, d0;
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    hold(1);
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL clear got count=%0d want 0", count);
    end
    d0 = down_cnt;
    step(2'b10);
    checks++;
    if (count !== 4'd15 || dir !== 1'b0 || down_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL wrap_down got count=%0d dir=%b down=%0d want 15 0 1", count, dir, down_cnt - d0);
    end
    u0 = up_cnt;
    step(2'b00);
    checks++;
    if (count !== 4'd0 || up_cnt - u0 !== 1) begin
      errors++;
      $display("FAIL wrap_up got count=%0d up=%0d want 0 1", count, up_cnt - u0);
    end
    d0 = down_cnt;
    step(2'b10);
    checks++;
    if (count !== 4'd15 || down_cnt - d0 !== 1) begin
      errors++;
      $display("FAIL wrap_down2 got count=%0d down=%0d want 15 1", count, down_cnt - d0);
    end
  endtask

  task automatic test_clear_collision;
    set_ab(2'b00);
    hold(6);
    @(negedge clk);
    clear = 1'b1;
    hold(1);
    checks++;
    if (count !== 4'd0 || up !== 1'b1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL clear_collide got count=%0d up=%b dir=%b want 0 1 1", count, up, dir);
    end
    @(negedge clk);
    clear = 1'b0;
    hold(1);
    checks++;
    if (up !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL clear_after got up=%b count=%0d want 0 0", up, count);
    end
    hold(5);
  endtask

  task automatic test_illegal;
    int u0, d0;
    logic exp_err;
`ifdef QUAD_DECODER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    step(2'b10);
    u0 = up_cnt;
    d0 = down_cnt;
    step(2'b01);
    checks++;
    if (up_cnt !== u0 || down_cnt !== d0 || count !== 4'd15 || dir !== 1'b0) begin
      errors++;
      $display("FAIL illegal got up=%0d down=%0d count=%0d dir=%b want 0 0 15 0", up_cnt - u0, down_cnt - d0, count, dir);
    end
    checks++;
    if (error !== exp_err) begin
      errors++;
      $display("FAIL illegal_err got %b want %b", error, exp_err);
    end
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    hold(1);
    checks++;
    if (error !== 1'b0 || count !== 4'd0) begin
      errors++;
      $display("FAIL err_clear got err=%b count=%0d want 0 0", error, count);
    end
  endtask

  task automatic test_reset_mid;
    int u0, d0;
    step(2'b11);
    checks++;
    if (count !== 4'd1 || dir !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got count=%0d dir=%b want 1 1", count, dir);
    end
    set_ab(2'b10);
    hold(4);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (count !== 4'd0 || dir !== 1'b0 || up !== 1'b0 || down !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got count=%0d dir=%b up=%b down=%b want 0 0 0 0", count, dir, up, down);
    end
    hold(3);
    u0 = up_cnt;
    d0 = down_cnt;
    @(negedge clk);
    reset = 1'b0;
    hold(20);
    checks++;
    if (up_cnt !== u0 || down_cnt !== d0 || count !== 4'd0) begin
      errors++;
      $display("FAIL post_reset got up=%0d down=%0d count=%0d want 0 0 0", up_cnt - u0, down_cnt - d0, count);
    end
    step(2'b00);
    checks++;
    if (up_cnt - u0 !== 1 || count !== 4'd1) begin
      errors++;
      $display("FAIL post_reset_step got up=%0d count=%0d want 1 1", up_cnt - u0, count);
    end
  endtask

  task automatic test_exclusive;
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL up_down_same got %0d cycles want 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_glitch();
    test_wrap();
    test_clear_collision();
    test_illegal();
    test_reset_mid();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
